evm_booth_scheduler: RTL and testbench

//  Session controller and arbiter that shares one 3-candidate tally datapath among N_BOOTH voting booths.

---
 rtl/evm_pkg.sv | 19 +
 rtl/evm_rr_arbiter.sv | 32 +++
 rtl/evm_booth_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_evm_booth_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared state encoding, candidate defaults and round-robin helper for the EVM booth scheduler.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CLEAR  = 2'b01,
    ST_OPEN   = 2'b10,
    ST_CLOSED = 2'b11
  } evm_state_e;

  localparam int EVM_CAND_W  = 2;
  localparam int EVM_N_CAND  = 3;
  localparam int EVM_AUDIT_W = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/evm_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first pending slot at or after ptr, wrapping to 0.
module evm_rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] slot_s;
  logic             hit_s;

  // Scan all slots from ptr onwards; the first pending one wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {IDX_W{1'b0}};
    slot_s      = {IDX_W{1'b0}};
    hit_s       = 1'b0;
    for (int i = 0; i < N; i++) begin
      slot_s      = IDX_W'((int'(ptr) + i) % N);
      hit_s       = pending[slot_s] & ~grant_valid;
      grant_idx   = hit_s ? slot_s : grant_idx;
      grant_valid = grant_valid | hit_s;
    end
    grant            = {N{1'b0}};
    grant[grant_idx] = grant_valid;
  end

endmodule

// File: rtl/evm_booth_scheduler.sv
// Session FSM and round-robin vote scheduler sharing one tally datapath among N_BOOTH booths.
// Define EVM_AUDIT_EN to add the o_audit_seq / o_audit_booth audit outputs.
module evm_booth_scheduler
  import evm_pkg::*;
#(
  parameter int N_BOOTH     = 4,
  parameter int N_CAND      = EVM_N_CAND,
  parameter int CAND_W      = EVM_CAND_W,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_session_open,
  input  logic [N_BOOTH-1:0]          i_booth_req,
  input  logic [N_BOOTH*CAND_W-1:0]   i_booth_cand,
  output logic [N_BOOTH-1:0]          o_booth_ack,
  output logic [N_BOOTH-1:0]          o_booth_busy,
  output logic                        o_reject,
  output logic                        o_tally_inc,
  output logic [CAND_W-1:0]           o_tally_cand,
  output logic                        o_tally_clear,
  output logic                        o_results_valid,
  output logic [1:0]                  o_state
`ifdef EVM_AUDIT_EN
  ,
  output logic [EVM_AUDIT_W-1:0]      o_audit_seq,
  output logic [$clog2(N_BOOTH)-1:0]  o_audit_booth
`endif
);

  localparam int IDX_W  = $clog2(N_BOOTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  evm_state_e         state_r;
  logic               clear_r;
  logic               results_r;
  logic               open_active_s;
  logic               enter_clear_s;
  logic [N_BOOTH-1:0] pend_s;
  logic [N_BOOTH-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_valid_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [CAND_W-1:0]  cand_sel_s;
  logic               cand_ok_s;
  logic [N_BOOTH-1:0] ack_r;
  logic               inc_r;
  logic               reject_r;
  logic [CAND_W-1:0]  tally_cand_r;

  // Votes are only scheduled while polls are open and staying open this cycle
  assign open_active_s = (state_r == ST_OPEN) && i_session_open;
  assign enter_clear_s = ((state_r == ST_IDLE) || (state_r == ST_CLOSED)) && i_session_open;
  assign cand_sel_s    = i_booth_cand[int'(grant_idx_s) * CAND_W +: CAND_W];
  assign cand_ok_s     = int'(cand_sel_s) < N_CAND;

  // Session sequencing with its registered clear / results strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      clear_r   <= 1'b0;
      results_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_CLOSED: begin
          if (enter_clear_s) begin
            state_r   <= ST_CLEAR;
            clear_r   <= 1'b1;
            results_r <= 1'b0;
          end else begin
            state_r   <= state_r;
            clear_r   <= 1'b0;
            results_r <= (state_r == ST_CLOSED);
          end
        end
        ST_CLEAR: begin
          state_r   <= ST_OPEN;
          clear_r   <= 1'b0;
          results_r <= 1'b0;
        end
        ST_OPEN: begin
          if (!i_session_open) begin
            state_r   <= ST_CLOSED;
            results_r <= 1'b1;
          end else begin
            state_r   <= ST_OPEN;
            results_r <= 1'b0;
          end
          clear_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          clear_r   <= 1'b0;
          results_r <= 1'b0;
        end
      endcase
    end
  end

  evm_rr_arbiter #(.N(N_BOOTH)) u_arb (
    .pending     (pend_s),
    .ptr         (ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  for (genvar b = 0; b < N_BOOTH; b++) begin : g_booth
    logic              req_r;
    logic              pend_r;
    logic [HOLD_W-1:0] hold_r;
    logic              busy_r;
    logic              pend_nxt_s;
    logic [HOLD_W-1:0] hold_nxt_s;

    // A booth in hold or already pending ignores request edges; closing drops everything
    always_comb begin
      pend_nxt_s = pend_r;
      hold_nxt_s = hold_r;
      if (!open_active_s) begin
        pend_nxt_s = 1'b0;
        hold_nxt_s = {HOLD_W{1'b0}};
      end else if (grant_s[b]) begin
        pend_nxt_s = 1'b0;
        hold_nxt_s = HOLD_W'(HOLD_CYCLES);
      end else if (hold_r != {HOLD_W{1'b0}}) begin
        hold_nxt_s = hold_r - HOLD_W'(1);
      end else if (i_booth_req[b] && !req_r && !pend_r) begin
        pend_nxt_s = 1'b1;
      end else begin
        pend_nxt_s = pend_r;
      end
    end

    // Per-booth request history, pending flag, lockout counter and busy flag
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        req_r  <= 1'b0;
        pend_r <= 1'b0;
        hold_r <= {HOLD_W{1'b0}};
        busy_r <= 1'b0;
      end else begin
        req_r  <= i_booth_req[b];
        pend_r <= pend_nxt_s;
        hold_r <= hold_nxt_s;
        busy_r <= pend_nxt_s | (hold_nxt_s != {HOLD_W{1'b0}});
      end
    end

    assign pend_s[b]       = pend_r;
    assign o_booth_busy[b] = busy_r;
  end

  // Registered grant results and round-robin pointer advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r        <= {N_BOOTH{1'b0}};
      inc_r        <= 1'b0;
      reject_r     <= 1'b0;
      tally_cand_r <= {CAND_W{1'b0}};
      ptr_r        <= {IDX_W{1'b0}};
    end else if (open_active_s && grant_valid_s) begin
      ack_r        <= grant_s;
      inc_r        <= cand_ok_s;
      reject_r     <= ~cand_ok_s;
      tally_cand_r <= cand_ok_s ? cand_sel_s : {CAND_W{1'b0}};
      ptr_r        <= IDX_W'(rr_next(int'(grant_idx_s), N_BOOTH));
    end else begin
      ack_r        <= {N_BOOTH{1'b0}};
      inc_r        <= 1'b0;
      reject_r     <= 1'b0;
      tally_cand_r <= {CAND_W{1'b0}};
      ptr_r        <= ptr_r;
    end
  end

  assign o_booth_ack     = ack_r;
  assign o_reject        = reject_r;
  assign o_tally_inc     = inc_r;
  assign o_tally_cand    = tally_cand_r;
  assign o_tally_clear   = clear_r;
  assign o_results_valid = results_r;
  assign o_state         = state_r;

`ifdef EVM_AUDIT_EN
  logic [EVM_AUDIT_W-1:0] audit_seq_r;
  logic [IDX_W-1:0]       audit_booth_r;

  // Per-session vote sequence number (wraps) and last granted booth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      audit_seq_r   <= {EVM_AUDIT_W{1'b0}};
      audit_booth_r <= {IDX_W{1'b0}};
    end else if (enter_clear_s) begin
      audit_seq_r   <= {EVM_AUDIT_W{1'b0}};
      audit_booth_r <= audit_booth_r;
    end else if (open_active_s && grant_valid_s) begin
      audit_seq_r   <= audit_seq_r + {{(EVM_AUDIT_W-1){1'b0}}, 1'b1};
      audit_booth_r <= grant_idx_s;
    end else begin
      audit_seq_r   <= audit_seq_r;
      audit_booth_r <= audit_booth_r;
    end
  end

  assign o_audit_seq   = audit_seq_r;
  assign o_audit_booth = audit_booth_r;
`endif

endmodule

// File: tb/tb_evm_booth_scheduler.sv
// Bench for evm_booth_scheduler: directed scenarios plus random traffic against an edge-level model.
`timescale 1ns/1ps
module tb_evm_booth_scheduler;
  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int NC   = 3;
  localparam int HOLD = 16;

  logic            clk, rst, sess;
  logic [N-1:0]    req;
  logic [N*CW-1:0] cand;
  logic [N-1:0]    o_booth_ack, o_booth_busy;
  logic            o_reject, o_tally_inc, o_tally_clear, o_results_valid;
  logic [CW-1:0]   o_tally_cand;
  logic [1:0]      o_state;
`ifdef EVM_AUDIT_EN
  logic [15:0]     o_audit_seq;
  logic [1:0]      o_audit_booth;
`endif

  int checks, failures, edge_no;

  // Reference model: session state, pending flags, edge index of each booth's last grant
  int m_state, m_ptr, m_seq, m_abooth;
  bit m_pend[N];
  bit m_prev[N];
  int m_gedge[N];
  logic [N-1:0]  e_ack, e_busy;
  logic          e_rej, e_inc, e_clear, e_res;
  logic [CW-1:0] e_cand;
  logic [15:0]   act_all, exp_all;

  assign act_all = {o_state, o_tally_clear, o_results_valid, o_booth_ack, o_booth_busy,
                    o_reject, o_tally_inc, o_tally_cand};
  assign exp_all = {2'(m_state), e_clear, e_res, e_ack, e_busy, e_rej, e_inc, e_cand};

  evm_booth_scheduler #(.N_BOOTH(N), .N_CAND(NC), .CAND_W(CW), .HOLD_CYCLES(HOLD)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_session_open  (sess),
    .i_booth_req     (req),
    .i_booth_cand    (cand),
    .o_booth_ack     (o_booth_ack),
    .o_booth_busy    (o_booth_busy),
    .o_reject        (o_reject),
    .o_tally_inc     (o_tally_inc),
    .o_tally_cand    (o_tally_cand),
    .o_tally_clear   (o_tally_clear),
    .o_results_valid (o_results_valid),
    .o_state         (o_state)
`ifdef EVM_AUDIT_EN
    ,
    .o_audit_seq     (o_audit_seq),
    .o_audit_booth   (o_audit_booth)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_seq = 0; m_abooth = 0;
    for (int b = 0; b < N; b++) begin
      m_pend[b] = 1'b0; m_prev[b] = 1'b0; m_gedge[b] = -1000;
    end
    e_ack = '0; e_busy = '0; e_rej = 1'b0; e_inc = 1'b0; e_clear = 1'b0; e_res = 1'b0; e_cand = '0;
  endtask

  task automatic model_edge();
    int g, nst, idx;
    logic [CW-1:0] c;
    e_ack = '0; e_inc = 1'b0; e_rej = 1'b0; e_cand = '0; e_clear = 1'b0;
    g = -1;
    if (m_state == 2 && sess) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && m_pend[idx]) g = idx;
      end
      if (g >= 0) begin
        c = cand[g*CW +: CW];
        e_ack[g] = 1'b1;
        if (int'(c) < NC) begin e_inc = 1'b1; e_cand = c; end
        else e_rej = 1'b1;
        m_pend[g] = 1'b0; m_gedge[g] = edge_no; m_ptr = (g + 1) % N;
        m_seq = (m_seq + 1) % 65536; m_abooth = g;
      end
      for (int b = 0; b < N; b++)
        if (req[b] && !m_prev[b] && !m_pend[b] && edge_no > m_gedge[b] + HOLD) m_pend[b] = 1'b1;
    end else begin
      for (int b = 0; b < N; b++) begin m_pend[b] = 1'b0; m_gedge[b] = -1000; end
    end
    for (int b = 0; b < N; b++) m_prev[b] = req[b];
    case (m_state)
      0, 3:    nst = sess ? 1 : m_state;
      1:       nst = 2;
      2:       nst = sess ? 2 : 3;
      default: nst = 0;
    endcase
    if (nst == 1) begin e_clear = 1'b1; m_seq = 0; end
    e_res = (nst == 3);
    m_state = nst;
    for (int b = 0; b < N; b++) e_busy[b] = m_pend[b] || (edge_no < m_gedge[b] + HOLD);
  endtask

  // One clock: model follows the DUT edge, outputs sampled 1ns later
  task automatic cycle();
    @(posedge clk);
    if (rst === 1'b1) model_edge();
    edge_no++;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0; sess = 1'b0; req = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic open_session();
    sess = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; sess = 1'b0; req = '0; cand = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_all !== 16'h0000) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", act_all, 16'h0000); end
    rst = 1'b1;
    cycle();
    checks++;
    if (act_all !== exp_all) begin failures++; $display("FAIL reset_idle got=%h exp=%h", act_all, exp_all); end
  endtask

  task automatic test_open();
    sess = 1'b1;
    cycle();
    checks++;
    if (o_state !== 2'b01 || o_tally_clear !== 1'b1 || o_results_valid !== 1'b0) begin
      failures++; $display("FAIL open_clear got state=%b clr=%b res=%b exp state=01 clr=1 res=0", o_state, o_tally_clear, o_results_valid);
    end
    cycle();
    checks++;
    if (o_state !== 2'b10 || o_tally_clear !== 1'b0) begin
      failures++; $display("FAIL open_state got state=%b clr=%b exp state=10 clr=0", o_state, o_tally_clear);
    end
    checks++;
    if (act_all !== exp_all) begin failures++; $display("FAIL open_model got=%h exp=%h", act_all, exp_all); end
  endtask

  task automatic test_single_vote();
    int busy_cnt;
    cand = '0; cand[1*CW +: CW] = 2'd2; req[1] = 1'b1;
    cycle();
    checks++;
    if (o_booth_ack !== 4'b0000 || o_booth_busy[1] !== 1'b1) begin
      failures++; $display("FAIL single_pending got ack=%b busy=%b exp ack=0000 busy[1]=1", o_booth_ack, o_booth_busy);
    end
    cycle();
    checks++;
    if (o_booth_ack !== 4'b0010 || o_tally_inc !== 1'b1 || o_tally_cand !== 2'd2 || o_reject !== 1'b0) begin
      failures++; $display("FAIL single_grant got ack=%b inc=%b cand=%0d rej=%b exp ack=0010 inc=1 cand=2 rej=0",
                           o_booth_ack, o_tally_inc, o_tally_cand, o_reject);
    end
    busy_cnt = o_booth_busy[1] ? 1 : 0;
    for (int k = 0; k < 22; k++) begin
      req[1] = (k == 4);
      cycle();
      if (o_booth_busy[1]) busy_cnt++;
      checks++;
      if (o_booth_ack !== 4'b0000) begin failures++; $display("FAIL single_repulse_ack k=%0d got=%b exp=0000", k, o_booth_ack); end
      checks++;
      if (act_all !== exp_all) begin failures++; $display("FAIL single_trace k=%0d got=%h exp=%h", k, act_all, exp_all); end
    end
    checks++;
    if (busy_cnt !== 16) begin failures++; $display("FAIL single_busy_len got=%0d exp=16", busy_cnt); end
  endtask

  task automatic test_contention();
    do_reset();
    open_session();
    for (int b = 0; b < N; b++) cand[b*CW +: CW] = CW'($urandom_range(0, NC - 1));
    req = 4'b1111;
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (o_booth_ack !== (4'b0001 << k)) begin
        failures++; $display("FAIL contention_order k=%0d got=%b exp=%b", k, o_booth_ack, 4'b0001 << k);
      end
      checks++;
      if (act_all !== exp_all) begin failures++; $display("FAIL contention_model k=%0d got=%h exp=%h", k, act_all, exp_all); end
    end
    req = 4'b0000;
    repeat (20) cycle();
    req = 4'b1001;
    cycle();
    cycle();
    checks++;
    if (o_booth_ack !== 4'b0001) begin failures++; $display("FAIL contention_ptr_wrap got=%b exp=0001", o_booth_ack); end
    cycle();
    checks++;
    if (o_booth_ack !== 4'b1000) begin failures++; $display("FAIL contention_second got=%b exp=1000", o_booth_ack); end
    req = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++;
      if (act_all !== exp_all) begin failures++; $display("FAIL contention_drain k=%0d got=%h exp=%h", k, act_all, exp_all); end
    end
  endtask

  task automatic test_invalid();
    cand[2*CW +: CW] = 2'd3; req[2] = 1'b1;
    cycle();
    cycle();
    checks++;
    if (o_booth_ack !== 4'b0100 || o_reject !== 1'b1 || o_tally_inc !== 1'b0 || o_booth_busy[2] !== 1'b1) begin
      failures++; $display("FAIL invalid_reject got ack=%b rej=%b inc=%b busy=%b exp ack=0100 rej=1 inc=0 busy[2]=1",
                           o_booth_ack, o_reject, o_tally_inc, o_booth_busy);
    end
    req[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++;
      if (act_all !== exp_all) begin failures++; $display("FAIL invalid_hold k=%0d got=%h exp=%h", k, act_all, exp_all); end
    end
  endtask

  task automatic test_close_pending();
    cand[3*CW +: CW] = 2'd1; req[3] = 1'b1;
    cycle();
    checks++;
    if (o_booth_busy[3] !== 1'b1) begin failures++; $display("FAIL close_pending_busy got=%b exp=1", o_booth_busy[3]); end
    sess = 1'b0;
    cycle();
    checks++;
    if (o_booth_ack !== 4'b0000 || o_tally_inc !== 1'b0 || o_state !== 2'b11 || o_results_valid !== 1'b1 || o_booth_busy !== 4'b0000) begin
      failures++; $display("FAIL close_drop got ack=%b inc=%b state=%b res=%b busy=%b exp 0000 0 11 1 0000",
                           o_booth_ack, o_tally_inc, o_state, o_results_valid, o_booth_busy);
    end
    req = 4'b0000;
    cycle();
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (o_booth_ack !== 4'b0000 || o_booth_busy !== 4'b0000 || o_results_valid !== 1'b1) begin
        failures++; $display("FAIL closed_ignore k=%0d got ack=%b busy=%b res=%b exp 0000 0000 1", k, o_booth_ack, o_booth_busy, o_results_valid);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    do_reset();
    sess = 1'b1;
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
        cand[b*CW +: CW] = CW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) sess = ~sess;
      cycle();
      checks++;
      if (act_all !== exp_all) begin failures++; $display("FAIL random k=%0d got=%h exp=%h", k, act_all, exp_all); end
`ifdef EVM_AUDIT_EN
      checks++;
      if (o_audit_seq !== 16'(m_seq) || o_audit_booth !== 2'(m_abooth)) begin
        failures++; $display("FAIL random_audit k=%0d got seq=%0d booth=%0d exp seq=%0d booth=%0d", k, o_audit_seq, o_audit_booth, m_seq, m_abooth);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    open_session();
    cand[0 +: CW] = 2'd0; req[0] = 1'b1;
    cycle();
    cycle();
    req[0] = 1'b0;
    repeat (3) cycle();
    checks++;
    if (o_booth_busy[0] !== 1'b1) begin failures++; $display("FAIL async_prehold got=%b exp=1", o_booth_busy[0]); end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_all !== 16'h0000 || o_state !== 2'b00) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", act_all, 16'h0000);
    end
`ifdef EVM_AUDIT_EN
    checks++;
    if (o_audit_seq !== 16'h0000) begin failures++; $display("FAIL async_audit got=%0d exp=0", o_audit_seq); end
`endif
    @(posedge clk);
    #1;
    sess = 1'b0;
    rst = 1'b1;
    cycle();
    checks++;
    if (act_all !== exp_all) begin failures++; $display("FAIL async_release got=%h exp=%h", act_all, exp_all); end
  endtask

  initial begin
    checks = 0; failures = 0; edge_no = 0;
    test_reset();
    test_open();
    test_single_vote();
    test_contention();
    test_invalid();
    test_close_pending();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
